multiplication: RTL and testbench
=================================

# multiplication

Sequential shift-and-add unsigned multiplier for the calculator datapath; the multiplicative counterpart of the combinational divider. It accepts two WIDTH-bit operands on a start pulse and iterates one multiplier bit per clock. It returns a 2*WIDTH-bit product with a one-cycle done strobe and an overflow flag, which tells the 4-bit display path whether the product fits in WIDTH bits.

## Interface
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- multiplicand  input  WIDTH  operand A; captured on the accepting edge.
- multiplier  input  WIDTH  operand B; captured on the accepting edge.
- product  output  2*WIDTH  result; holds its last value until the next accepted start.
- overflow  output  1  product[2*WIDTH-1:WIDTH] != 0; valid whenever done is high, held with product.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle strobe in DONE.

## Operation
- States: IDLE, RUN, DONE, encoded 2'b00, 2'b01, 2'b10.
- IDLE with start=1:
  - latch A into a 2*WIDTH shift register, zero-extended.
  - latch B into a WIDTH shift register.
  - clear the accumulator and the bit counter.
  - go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN, each edge:
  - if B[0]=1, accumulator += A, computed modulo 2^(2*WIDTH); this can never truncate.
  - A <<= 1, B >>= 1, counter += 1.
  - when counter reaches WIDTH-1, go to DONE.
- DONE:
  - product and overflow are driven from the accumulator.
  - done=1 for exactly one cycle, then the block returns to IDLE.
- start while in RUN or DONE: ignored; operands are not re-sampled.
- Operand inputs may change freely after the accepting edge.
- Reset, asynchronous, at any time including mid-RUN:
  - state=IDLE, product=0, overflow=0, busy=0, done=0.
  - accumulator, shift registers and counter are cleared.
  - the in-flight operation is discarded with no done pulse.
- Zero operands are legal: the result is product 0, overflow 0, with normal latency.

## Timing
- E0 is the edge that accepts start.
- busy is high from E0 to E_WIDTH.
- done is high from E_WIDTH to E_WIDTH+1.
- Base latency: done appears WIDTH clocks after E0 (4 for the default WIDTH).
- Earliest next acceptance is at edge E_WIDTH+2, i.e. start must be held or re-asserted in IDLE.
- Throughput is one product per WIDTH+2 clocks.
- product and overflow update only on the DONE-entry edge and are stable otherwise.

## Configuration
- Macro: MULTIPLICATION_EARLY_DONE_EN.
- Defined:
  - in RUN, if the shifted multiplier register becomes zero after a step, go to DONE on that same edge.
  - latency becomes max(1, index of highest set bit of B + 1) clocks.
  - B=0 or B=1 gives done one clock after E0.
  - the result is identical to the full-length case.
- Undefined: always exactly WIDTH RUN steps, and the zero-detect logic is not synthesized.

## Structure
- Shared package calc_pkg holds:
  - the state encoding localparams (IDLE, RUN, DONE).
  - the default calculator operand width (4), shared with the divider and other calculator operations.
- One sub-module is natural: multiplication_step. It is a combinational single shift-add step: inputs accumulator, A, B; outputs next accumulator, A<<1, B>>1.
- The FSM, counter and registers stay in the top.

## Test plan
- Basic: 3x5, start pulse → busy for 4 cycles, then done 1 cycle, product=8'd15, overflow=0.
- Overflow: 15x15 → product=8'd225, overflow=1.
- Start while busy: start 6x7, re-assert start with 2x2 during RUN → single done with product=8'd42; second request ignored.
- Reset mid-operation: 9x9, reset at the second RUN cycle → all outputs 0 immediately and no done. Then 2x3 → product=8'd6.
- Back-to-back: 4x4 then 7x3, start held high → products 16 then 21; second done exactly 6 clocks after the first.
- MULTIPLICATION_EARLY_DONE_EN: 13x1 → done 1 clock after E0, product=8'd13. 13x8 → done after 4 clocks, product=8'd104. Undefined: both take 4 clocks.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator definitions: operand width and sequencer state encoding
package calc_pkg;

  // Default operand width shared by the calculator operations (multiplier, divider, ...)
  localparam int CALC_WIDTH = 4;

  // Sequencer states for the multi-cycle calculator operations
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/multiplication_step.sv
// rtl/multiplication_step.sv - one combinational shift-and-add multiplier step
module multiplication_step
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] a_next,
  output logic [WIDTH-1:0]   b_next
);

  // Add the shifted multiplicand when the current multiplier LSB is set; the
  // accumulator is 2*WIDTH wide so the sum of partial products never wraps.
  always_comb begin
    acc_next = b[0] ? (acc + a) : acc;
    a_next   = a << 1;
    b_next   = b >> 1;
  end

endmodule

// File: rtl/multiplication.sv
// rtl/multiplication.sv - sequential shift-and-add unsigned multiplier (option: MULTIPLICATION_EARLY_DONE_EN)
module multiplication
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               overflow,
  output logic               busy,
  output logic               done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [CW-1:0]      cnt;

  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] a_next;
  logic [WIDTH-1:0]   b_next;
  logic               last_step;

  multiplication_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc      (acc),
    .a        (a_reg),
    .b        (b_reg),
    .acc_next (acc_next),
    .a_next   (a_next),
    .b_next   (b_next)
  );

`ifdef MULTIPLICATION_EARLY_DONE_EN
  // Stop once no multiplier bits remain: later steps could only add zero
  assign last_step = (cnt == CW'(WIDTH - 1)) || (b_next == '0);
`else
  assign last_step = (cnt == CW'(WIDTH - 1));
`endif

  // Sequencer: accept operands in IDLE, one multiplier bit per clock in RUN,
  // publish the product on the DONE-entry edge and strobe done for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      cnt      <= '0;
      product  <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= {{WIDTH{1'b0}}, multiplicand};
            b_reg <= multiplier;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          a_reg <= a_next;
          b_reg <= b_next;
          cnt   <= cnt + CW'(1);
          if (last_step) begin
            product  <= acc_next;
            overflow <= |acc_next[2*WIDTH-1:WIDTH];
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplication.sv
// tb/tb_multiplication.sv - randomized self-checking bench for multiplication (option: MULTIPLICATION_EARLY_DONE_EN)
module tb_multiplication;

  localparam int W = 4;

  logic           clk;
  logic           reset;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [2*W-1:0] product;
  logic           overflow;
  logic           busy;
  logic           done;

  int n_tests;
  int n_fail;

  multiplication #(
    .WIDTH (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .overflow     (overflow),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference latency in clocks from the accepting edge to done
  function automatic int exp_lat(input int b);
    int h;
    h = 0;
`ifdef MULTIPLICATION_EARLY_DONE_EN
    for (int i = 0; i < W; i++)
      if (((b >> i) & 1) == 1) h = i + 1;
    if (h < 1) h = 1;
`else
    h = W;
`endif
    return h;
  endfunction

  // One full operation starting from IDLE at edge+#1; ends back in IDLE at edge+#1
  task automatic run_op(input int a, input int b, input string tag);
    int lat;
    int p;
    p = a * b;
    start        = 1'b1;
    multiplicand = W'(a);
    multiplier   = W'(b);
    @(posedge clk); #1;
    start        = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    check({tag, "_busy_e0"}, 32'(busy), 1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat(b));
    check({tag, "_product"}, 32'(product), p);
    check({tag, "_overflow"}, 32'(overflow), (p >= (1 << W)) ? 1 : 0);
    check({tag, "_busy_done"}, 32'(busy), 0);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 32'(done), 0);
  endtask

  initial begin
    int nd;
    int cyc;
    int d1;
    int d2;
    int a;
    int b;
    n_tests      = 0;
    n_fail       = 0;
    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_product", 32'(product), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(3, 5, "basic_3x5");
    run_op(15, 15, "ovf_15x15");
    run_op(0, 0, "zero_0x0");
    run_op(0, 15, "zero_0x15");
    run_op(13, 1, "early_13x1");
    run_op(13, 8, "early_13x8");

    // Start re-asserted during RUN must be ignored
    start = 1'b1; multiplicand = 4'd6; multiplier = 4'd7;
    @(posedge clk); #1;
    multiplicand = 4'd2; multiplier = 4'd2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        check("busy_start_product", 32'(product), 42);
      end
    end
    check("busy_start_done_count", nd, 1);
    check("busy_start_product_held", 32'(product), 42);

    // Asynchronous reset during the second RUN cycle
    start = 1'b1; multiplicand = 4'd9; multiplier = 4'd9;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("midrst_product", 32'(product), 0);
    check("midrst_overflow", 32'(overflow), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("midrst_no_done", nd, 0);
    run_op(2, 3, "after_rst_2x3");

    // Back-to-back with start held high
    start = 1'b1; multiplicand = 4'd4; multiplier = 4'd4;
    @(posedge clk); #1;
    multiplicand = 4'd7; multiplier = 4'd3;
    cyc = 0; d1 = -1; d2 = -1;
    while (cyc < 30 && d2 < 0) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        if (d1 < 0) begin
          d1 = cyc;
          check("b2b_first_product", 32'(product), 16);
        end else begin
          d2 = cyc;
          check("b2b_second_product", 32'(product), 21);
        end
      end
      if (d1 >= 0 && busy) start = 1'b0;
    end
    start = 1'b0;
    check("b2b_first_latency", d1, exp_lat(4));
    check("b2b_spacing", d2 - d1, exp_lat(3) + 2);
    @(posedge clk); #1;

    // Randomized operands against the arithmetic model
    for (int k = 0; k < 30; k++) begin
      a = int'($urandom_range(0, (1 << W) - 1));
      b = int'($urandom_range(0, (1 << W) - 1));
      run_op(a, b, $sformatf("rand%0d_%0dx%0d", k, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
